viterbi_frame_ctrl: RTL

Frame-level sequencer for viterbi_core. It accepts framed coded-symbol pairs from upstream and clears the core between frames. After each frame it injects flush symbols so that all decoded bits emerge from traceback. It strips the warm-up and tail bits from the core output and re-frames the surviving bits with sof/eof markers.

---
 rtl/viterbi_pkg.sv | 17 +
 rtl/viterbi_out_framer.sv | 70 +++++++
 rtl/viterbi_frame_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants for the Viterbi frame controller: FSM state encodings,
// symbol width and default latency/tail parameters.
package viterbi_pkg;

  localparam int unsigned SymW       = 2;
  localparam int unsigned TbDepthDef = 16;
  localparam int unsigned TailLenDef = 2;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StClear = 3'd1;
  localparam state_t StRun   = 3'd2;
  localparam state_t StFlush = 3'd3;
  localparam state_t StDrain = 3'd4;

endpackage

// File: rtl/viterbi_out_framer.sv
// Counts core output strobes per frame, discards warm-up and tail bits and
// re-frames the surviving payload bits with sof/eof markers.
module viterbi_out_framer
  import viterbi_pkg::*;
#(
  parameter int unsigned TB_DEPTH = TbDepthDef,
  parameter int unsigned TAIL_LEN = TailLenDef,
  parameter int unsigned CNT_W    = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             active,
  input  logic             len_final,
  input  logic [CNT_W-1:0] frame_len,
  input  logic             dec,
  input  logic             dec_valid,
  output logic [CNT_W-1:0] out_cnt,
  output logic             m_bit,
  output logic             m_valid,
  output logic             m_sof,
  output logic             m_eof
);

  localparam logic [CNT_W-1:0] TbDepthC = CNT_W'(TB_DEPTH);
  localparam logic [CNT_W-1:0] TailLenC = CNT_W'(TAIL_LEN);
  localparam logic [CNT_W-1:0] OneC     = CNT_W'(1);

  logic [CNT_W-1:0] out_cnt_q;
  logic             pulse, in_payload, fwd, is_first, is_last;
  logic             m_bit_q, m_valid_q, m_sof_q, m_eof_q;

  // Before the frame length is final, any bit past warm-up is payload: the
  // core lags the input by TB_DEPTH symbols, so tail bits only emerge later.
  always_comb begin
    pulse      = active && dec_valid;
    in_payload = !len_final ||
                 ((frame_len > TailLenC) && (out_cnt_q + TailLenC < TbDepthC + frame_len));
    fwd        = pulse && (out_cnt_q >= TbDepthC) && in_payload;
    is_first   = (out_cnt_q == TbDepthC);
    is_last    = len_final && (out_cnt_q + TailLenC + OneC == TbDepthC + frame_len);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt_q <= '0;
      m_bit_q   <= 1'b0;
      m_valid_q <= 1'b0;
      m_sof_q   <= 1'b0;
      m_eof_q   <= 1'b0;
    end else begin
      m_valid_q <= fwd;
      m_sof_q   <= fwd && is_first;
      m_eof_q   <= fwd && is_last;
      m_bit_q   <= fwd && dec;
      if (clear) begin
        out_cnt_q <= '0;
      end else if (pulse) begin
        out_cnt_q <= out_cnt_q + OneC;
      end
    end
  end

  assign out_cnt = out_cnt_q;
  assign m_bit   = m_bit_q;
  assign m_valid = m_valid_q;
  assign m_sof   = m_sof_q;
  assign m_eof   = m_eof_q;

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for viterbi_core: clears the core, feeds symbols, flushes
// traceback and re-frames output. VITERBI_CTRL_STATS_EN adds frame/error counters.
module viterbi_frame_ctrl
  import viterbi_pkg::*;
#(
  parameter int unsigned TB_DEPTH  = TbDepthDef,
  parameter int unsigned TAIL_LEN  = TailLenDef,
  parameter int unsigned MAX_FRAME = 1024,
  parameter int unsigned CLR_CYC   = 2,
  parameter int unsigned CNT_W     = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SymW-1:0] s_sym_i,
  input  logic            s_valid_i,
  input  logic            s_sof_i,
  input  logic            s_eof_i,
  output logic            s_ready_o,
  output logic            core_rst_n_o,
  output logic [SymW-1:0] core_data_o,
  output logic            core_valid_o,
  input  logic            core_dec_i,
  input  logic            core_dec_valid_i,
  output logic            m_bit_o,
  output logic            m_valid_o,
  output logic            m_sof_o,
  output logic            m_eof_o,
  output logic            busy_o,
  output logic            frame_err_o
`ifdef VITERBI_CTRL_STATS_EN
  ,
  output logic [15:0]     frame_cnt_o,
  output logic [7:0]      err_cnt_o
`endif
);

  localparam logic [CNT_W-1:0] TbDepthC   = CNT_W'(TB_DEPTH);
  localparam logic [CNT_W-1:0] TailLenC   = CNT_W'(TAIL_LEN);
  localparam logic [CNT_W-1:0] MaxFrameC  = CNT_W'(MAX_FRAME);
  localparam logic [CNT_W-1:0] ClrLastC   = CNT_W'(CLR_CYC - 1);
  localparam logic [CNT_W-1:0] FlushLastC = CNT_W'(TB_DEPTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] in_cnt_q, in_next, aux_cnt_q, out_cnt;
  logic [SymW-1:0]  core_data_q;
  logic             core_valid_q, core_rst_n_q, err_q, err_set, hs;

  assign in_next = in_cnt_q + CNT_W'(1);
  assign hs      = s_valid_i && s_ready_o;

  // In IDLE the sof beat is left on the bus so RUN accepts it as symbol 0.
  always_comb begin
    state_d   = state_q;
    s_ready_o = 1'b0;
    err_set   = 1'b0;
    case (state_q)
      StIdle: begin
        if (s_valid_i) begin
          if (s_sof_i) begin
            state_d = StClear;
          end else begin
            s_ready_o = 1'b1;
            err_set   = 1'b1;
          end
        end
      end
      StClear: begin
        if (aux_cnt_q == ClrLastC) state_d = StRun;
      end
      StRun: begin
        s_ready_o = 1'b1;
        if (s_valid_i) begin
          if (s_sof_i && (in_cnt_q != '0)) err_set = 1'b1;
          if (s_eof_i || (in_next == MaxFrameC)) begin
            state_d = StFlush;
            if (!s_eof_i || (in_next <= TailLenC)) err_set = 1'b1;
          end
        end
      end
      StFlush: begin
        if (aux_cnt_q == FlushLastC) state_d = StDrain;
      end
      StDrain: begin
        if (out_cnt == in_cnt_q + TbDepthC) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      in_cnt_q     <= '0;
      aux_cnt_q    <= '0;
      core_data_q  <= '0;
      core_valid_q <= 1'b0;
      core_rst_n_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      aux_cnt_q    <= (state_d != state_q) ? '0 : aux_cnt_q + CNT_W'(1);
      core_rst_n_q <= (state_d != StClear);
      err_q        <= err_q | err_set;
      core_valid_q <= 1'b0;
      if (state_q == StClear) in_cnt_q <= '0;
      if ((state_q == StRun) && hs) begin
        core_data_q  <= s_sym_i;
        core_valid_q <= 1'b1;
        in_cnt_q     <= in_next;
      end
      if (state_q == StFlush) begin
        core_data_q  <= '0;
        core_valid_q <= 1'b1;
      end
    end
  end

  viterbi_out_framer #(
    .TB_DEPTH (TB_DEPTH),
    .TAIL_LEN (TAIL_LEN),
    .CNT_W    (CNT_W)
  ) u_framer (
    .clk       (clk),
    .rst       (rst),
    .clear     (state_q == StClear),
    .active    ((state_q == StRun) || (state_q == StFlush) || (state_q == StDrain)),
    .len_final ((state_q == StFlush) || (state_q == StDrain)),
    .frame_len (in_cnt_q),
    .dec       (core_dec_i),
    .dec_valid (core_dec_valid_i),
    .out_cnt   (out_cnt),
    .m_bit     (m_bit_o),
    .m_valid   (m_valid_o),
    .m_sof     (m_sof_o),
    .m_eof     (m_eof_o)
  );

`ifdef VITERBI_CTRL_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if ((state_q == StDrain) && (state_d == StIdle) && (frame_cnt_q != '1)) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (err_set && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign err_cnt_o   = err_cnt_q;
`endif

  assign core_rst_n_o = core_rst_n_q;
  assign core_data_o  = core_data_q;
  assign core_valid_o = core_valid_q;
  assign busy_o       = (state_q != StIdle);
  assign frame_err_o  = err_q;

endmodule
